// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared constants and helpers for the timebase chain:
//               default clock rate, stage modulus array type, the usual
//               seconds/minutes/hours moduli and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam int c_default_clk_hz    = 50_000_000;
    localparam int c_default_num_stages = 3;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

    typedef int stage_mod_t [c_default_num_stages];

    localparam stage_mod_t c_default_stage_mod = '{SEC_MOD, MIN_MOD, HOUR_MOD};

    // Prescaler counter width; a divide-by-one still needs a 1-bit register.
    function automatic int calc_div_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Width of a stage-select field; a single stage still needs one bit.
    function automatic int calc_sel_w(input int num_stages);
        return (num_stages > 1) ? $clog2(num_stages) : 1;
    endfunction

endpackage : clock_pkg
`default_nettype wire

// File: rtl/timebase_chain_mod_stage.sv
`default_nettype none
// ============================================================================
// Module      : mod_stage
// Description : One modulo-MOD counter of the timebase chain. Advances on
//               ce, wraps to zero at MOD-1 and flags the wrap on carry.
//               A load overrides the advance for this stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_stage
    import clock_pkg::*;
#(
    parameter int MOD = SEC_MOD,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] value,
    output logic         at_max,
    output logic         carry
);

    logic [W-1:0] r_value;

    assign value  = r_value;
    assign at_max = (r_value == W'(MOD - 1));
    assign carry  = ce & at_max;

    // Stage register: reset, then load, then modulo advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value <= '0;
        end else if (ld) begin
            r_value <= ld_val;
        end else if (ce) begin
            r_value <= at_max ? '0 : r_value + W'(1);
        end
    end

endmodule : mod_stage
`default_nettype wire

// File: rtl/timebase_chain.sv
`default_nettype none
// ============================================================================
// Module      : timebase_chain
// Description : Base prescaler producing a one-cycle tick every
//               CLK_HZ/TICK_HZ enabled clocks, feeding a cascade of modulo
//               stages with per-stage carries, manual step and per-stage
//               load for time setting.
// Revision    : 1.0 - initial release
// ============================================================================
module timebase_chain
    import clock_pkg::*;
#(
    parameter int CLK_HZ                = c_default_clk_hz,
    parameter int TICK_HZ               = 1,
    parameter int NUM_STAGES            = c_default_num_stages,
    parameter int STAGE_W               = 6,
    parameter int STAGE_MOD [NUM_STAGES] = '{SEC_MOD, MIN_MOD, HOUR_MOD}
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  prescale_clr,
    input  logic                                  step,
    input  logic                                  load,
    input  logic [calc_sel_w(NUM_STAGES)-1:0]     load_stage,
    input  logic [STAGE_W-1:0]                    load_value,
    output logic                                  tick,
    output logic [NUM_STAGES-1:0][STAGE_W-1:0]    value,
    output logic [NUM_STAGES-1:0]                 carry,
    output logic                                  rollover,
    output logic                                  load_err
);

    localparam int c_div   = CLK_HZ / TICK_HZ;
    localparam int c_div_w = calc_div_w(c_div);

    // Parameter sanity checks, evaluated at elaboration.
    if (c_div < 1) begin : g_chk_div
        $error("timebase_chain: CLK_HZ/TICK_HZ must be at least 1");
    end
    if ((CLK_HZ % TICK_HZ) != 0) begin : g_chk_divisible
        $error("timebase_chain: CLK_HZ must be an integer multiple of TICK_HZ");
    end
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_chk_mod
        if ((STAGE_MOD[g] < 2) || (STAGE_MOD[g] > (2 ** STAGE_W))) begin : g_bad
            $error("timebase_chain: STAGE_MOD out of range for STAGE_W");
        end
    end

    logic [c_div_w-1:0]    r_cnt;
    logic                  r_load_err;
    logic                  w_tick;
    logic                  w_adv;
    logic [NUM_STAGES:0]   w_ce;
    logic [NUM_STAGES-1:0] w_at_max;
    logic [NUM_STAGES-1:0] w_ld;
    logic                  w_load_bad;

    // Tick on the last count of an enabled, uncleared cycle; never in reset.
    assign w_tick   = rst & en & ~prescale_clr & (r_cnt == c_div_w'(c_div - 1));
    assign w_adv    = rst & (w_tick | step);
    assign tick     = w_tick;
    assign rollover = w_ce[NUM_STAGES];
    assign load_err = r_load_err;

    // Prescaler: clear beats enable, wraps on the tick cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (prescale_clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_tick ? '0 : r_cnt + c_div_w'(1);
        end
    end

    // Ripple enable: stage i advances when all lower stages sit at their max.
    always_comb begin
        w_ce    = '0;
        w_ce[0] = w_adv;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_ce[i+1] = w_ce[i] & w_at_max[i];
        end
    end

    // Load decode: only an in-range stage with an in-range value is accepted.
    always_comb begin
        w_ld = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (load && (int'(load_stage) == i) && (int'(load_value) < STAGE_MOD[i])) begin
                w_ld[i] = 1'b1;
            end
        end
        w_load_bad = load & ~(|w_ld);
    end

    // Rejected-load flag lasts exactly one cycle after the bad request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= w_load_bad;
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        mod_stage #(
            .MOD (STAGE_MOD[g]),
            .W   (STAGE_W)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .ce     (w_ce[g]),
            .ld     (w_ld[g]),
            .ld_val (load_value),
            .value  (value[g]),
            .at_max (w_at_max[g]),
            .carry  (carry[g])
        );
    end

endmodule : timebase_chain
`default_nettype wire

// File: tb/tb_timebase_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_timebase_chain
// Description : Self-checking bench for timebase_chain (DIV=10, moduli
//               4/3/2). The chain is modelled as one integer time count
//               in mixed radix; stage values and carries are derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timebase_chain;

    localparam int DIV   = 10;
    localparam int NS    = 3;
    localparam int W     = 3;
    localparam int MODS [NS] = '{4, 3, 2};
    localparam int TOTAL = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              prescale_clr = 1'b0;
    logic              step = 1'b0;
    logic              load = 1'b0;
    logic [1:0]        load_stage = '0;
    logic [W-1:0]      load_value = '0;
    logic              tick;
    logic [NS-1:0][W-1:0] value;
    logic [NS-1:0]     carry;
    logic              rollover;
    logic              load_err;

    int checks   = 0;
    int failures = 0;

    // Reference state: prescaler count, whole-chain time, pending load error.
    int m_cnt = 0;
    int m_t   = 0;
    int m_err = 0;
    bit chk_en = 1'b0;
    int nt;
    int adv;
    bit valid;

    timebase_chain #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .NUM_STAGES (NS),
        .STAGE_W    (W),
        .STAGE_MOD  (MODS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .prescale_clr (prescale_clr),
        .step         (step),
        .load         (load),
        .load_stage   (load_stage),
        .load_value   (load_value),
        .tick         (tick),
        .value        (value),
        .carry        (carry),
        .rollover     (rollover),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int base_of(input int i);
        int b = 1;
        for (int j = 0; j < i; j++) b *= MODS[j];
        return b;
    endfunction

    function automatic int digit(input int t, input int i);
        return (t / base_of(i)) % MODS[i];
    endfunction

    function automatic int m_tick();
        return (rst && en && !prescale_clr && (m_cnt == DIV - 1)) ? 1 : 0;
    endfunction

    function automatic int m_adv();
        return (rst && ((m_tick() != 0) || step)) ? 1 : 0;
    endfunction

    // Stage i wraps exactly when the advanced time is a multiple of its base.
    function automatic int m_carry(input int i);
        return ((m_adv() != 0) && (((m_t + 1) % base_of(i + 1)) == 0)) ? 1 : 0;
    endfunction

    // Reference model update on each active edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_cnt = 0;
            m_t   = 0;
            m_err = 0;
        end else begin
            adv = m_adv();
            valid = 1'b0;
            if (int'(load_stage) < NS) begin
                if (int'(load_value) < MODS[load_stage]) valid = 1'b1;
            end
            nt = (adv != 0) ? (m_t + 1) % TOTAL : m_t;
            if (load && valid) begin
                nt = nt - digit(nt, int'(load_stage)) * base_of(int'(load_stage))
                        + int'(load_value) * base_of(int'(load_stage));
            end
            m_err = (load && !valid) ? 1 : 0;
            if (prescale_clr)  m_cnt = 0;
            else if (en)       m_cnt = (m_cnt + 1) % DIV;
            m_t = nt;
        end
        chk_en = 1'b1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tick", int'(tick), m_tick());
            for (int i = 0; i < NS; i++) begin
                chk($sformatf("carry%0d", i), int'(carry[i]), m_carry(i));
                chk($sformatf("value%0d", i), int'(value[i]), digit(m_t, i));
            end
            chk("rollover", int'(rollover), m_carry(NS - 1));
            chk("load_err", int'(load_err), m_err);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles (current one = 1) until tick; -1 if the budget expires.
    task automatic wait_tick(input int maxc, output int n);
        n = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    int n;
    int n_tick, n_c0, n_c1, n_roll, n_hold;

    initial begin
        repeat (3) nxt();
        rst = 1'b1;
        en  = 1'b1;

        // First tick lands on the tenth cycle after release.
        wait_tick(20, n);
        chk("first_tick_cycle", n, 10);
        @(negedge clk);
        chk("v0_after_tick1", int'(value[0]), 1);

        // Run the full 24-tick period and count events.
        n_tick = 1; n_c0 = 0; n_c1 = 0; n_roll = 0;
        for (int k = 12; k <= 241; k++) begin
            @(negedge clk);
            n_tick += int'(tick);
            n_c0   += int'(carry[0]);
            n_c1   += int'(carry[1]);
            n_roll += int'(rollover);
        end
        chk("tick_count", n_tick, 24);
        chk("carry0_count", n_c0, 6);
        chk("carry1_count", n_c1, 2);
        chk("rollover_count", n_roll, 1);
        chk("wrap_v0", int'(value[0]), 0);
        chk("wrap_v1", int'(value[1]), 0);
        chk("wrap_v2", int'(value[2]), 0);

        // Hold enable low with the prescaler at 5.
        nxt();
        repeat (4) nxt();
        en = 1'b0;
        n_hold = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_hold += int'(tick);
            nxt();
        end
        chk("hold_ticks", n_hold, 0);
        en = 1'b1;
        wait_tick(20, n);
        chk("tick_after_hold", n, 5);

        // Clear at count 9 suppresses the tick and restarts the count.
        repeat (10) nxt();
        prescale_clr = 1'b1;
        @(negedge clk);
        chk("clr_no_tick", int'(tick), 0);
        nxt();
        prescale_clr = 1'b0;
        wait_tick(20, n);
        chk("tick_after_clr", n, 10);

        // Valid and rejected loads.
        nxt();
        en = 1'b0;
        load = 1'b1; load_stage = 2'd1; load_value = 3'd2;
        nxt();
        load = 1'b0;
        @(negedge clk);
        chk("load_v1", int'(value[1]), 2);
        chk("load_ok_err", int'(load_err), 0);
        nxt();
        load = 1'b1; load_stage = 2'd0; load_value = 3'd4;
        nxt();
        load = 1'b0;
        @(negedge clk);
        chk("bad_value_err", int'(load_err), 1);
        chk("bad_value_v0", int'(value[0]), 2);
        nxt();
        @(negedge clk);
        chk("err_one_cycle", int'(load_err), 0);
        nxt();
        load = 1'b1; load_stage = 2'd3; load_value = 3'd0;
        nxt();
        load = 1'b0;
        @(negedge clk);
        chk("bad_stage_err", int'(load_err), 1);

        // Step coincident with tick gives a single advance.
        nxt();
        load = 1'b1; load_stage = 2'd0; load_value = 3'd3; prescale_clr = 1'b1;
        nxt();
        load_stage = 2'd1; load_value = 3'd1; prescale_clr = 1'b0;
        nxt();
        load = 1'b0; en = 1'b1;
        repeat (9) nxt();
        step = 1'b1;
        @(negedge clk);
        chk("step_tick", int'(tick), 1);
        chk("step_carry0", int'(carry[0]), 1);
        chk("step_carry1", int'(carry[1]), 0);
        nxt();
        step = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("step_v0", int'(value[0]), 0);
        chk("step_v1", int'(value[1]), 2);
        chk("step_carry0_off", int'(carry[0]), 0);

        // Mid-operation reset.
        nxt();
        load = 1'b1; load_stage = 2'd0; load_value = 3'd3; prescale_clr = 1'b1;
        nxt();
        load_stage = 2'd1; load_value = 3'd2; prescale_clr = 1'b0;
        nxt();
        load_stage = 2'd2; load_value = 3'd1;
        nxt();
        load = 1'b0; en = 1'b1;
        repeat (7) nxt();
        step = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_tick", int'(tick), 0);
        chk("rst_no_carry", int'(carry), 0);
        chk("rst_pre_v0", int'(value[0]), 3);
        nxt();
        step = 1'b0;
        rst = 1'b1;
        chk("rst_v0", int'(value[0]), 0);
        chk("rst_v1", int'(value[1]), 0);
        chk("rst_v2", int'(value[2]), 0);
        wait_tick(20, n);
        chk("tick_after_rst", n, 10);

        // Randomized traffic checked by the per-cycle comparison.
        for (int k = 0; k < 3000; k++) begin
            nxt();
            rst          = ($urandom_range(0, 199) != 0);
            en           = ($urandom_range(0, 9) != 0);
            prescale_clr = ($urandom_range(0, 29) == 0);
            step         = ($urandom_range(0, 14) == 0);
            load         = ($urandom_range(0, 19) == 0);
            load_stage   = 2'($urandom_range(0, 3));
            load_value   = 3'($urandom_range(0, 7));
        end
        nxt();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_timebase_chain
`default_nettype wire

// File: doc/timebase_chain.md
Name: timebase_chain

Overview:
Parametrised timebase for the clock datapath. It replaces a single fixed-period tick counter with two parts: a base prescaler that emits a one-cycle tick at TICK_HZ, and a chain of NUM_STAGES cascaded modulo counters (e.g. seconds/minutes/hours) with per-stage carry pulses. It supports runtime enable, prescaler clear, a manual step input and per-stage load for time setting. It sits between the board clock and the display/alarm logic.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 1, base tick rate in Hz; DIV = CLK_HZ/TICK_HZ clocks per tick
NUM_STAGES, 3, number of cascaded modulo stages
STAGE_W, 6, width of each stage value
STAGE_MOD, '{60,60,24}, int array [NUM_STAGES], modulus per stage, index 0 = least significant

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
en  in  1  prescaler count enable
prescale_clr  in  1  synchronous clear of prescaler only
step  in  1  one-cycle manual advance of stage 0
load  in  1  one-cycle load strobe
load_stage  in  $clog2(NUM_STAGES) or 1 if NUM_STAGES=1  target stage index
load_value  in  STAGE_W  value to load
tick  out  1  base tick pulse
value  out  [NUM_STAGES][STAGE_W]  registered stage values
carry  out  NUM_STAGES  stage wrap pulse
rollover  out  1  whole-chain wrap pulse
load_err  out  1  registered pulse, rejected load

Behaviour:
- Reset (rst=0 at clk edge): prescaler=0, all value=0, load_err=0. tick, carry and rollover are 0 during any reset cycle.
- Prescaler: DIV_W = max(1,$clog2(DIV)). Counts 0..DIV-1 only while en=1; holds when en=0. prescale_clr=1 forces it to 0 and has priority over en. DIV=1 gives tick on every enabled cycle.
- tick is combinational: en & ~prescale_clr & (cnt==DIV-1). Prescaler wraps to 0 on the same edge.
- adv = tick | step. tick and step together produce exactly one advance.
- Stage i enable: ce[i] = adv & (value[j]==STAGE_MOD[j]-1 for all j<i). Stage 0 uses ce[0]=adv.
- On ce[i], value[i] <= (value[i]==STAGE_MOD[i]-1) ? 0 : value[i]+1. Latency: value updates on the edge closing the tick cycle and is visible the next cycle.
- carry[i] = ce[i] & (value[i]==STAGE_MOD[i]-1). It is combinational and aligned with tick.
- rollover = carry[NUM_STAGES-1].
- Load: valid when load_stage<NUM_STAGES and load_value<STAGE_MOD[load_stage]. A valid load writes the target stage and takes priority over ce for that stage only. Other stages still advance, with carries computed from pre-load values.
- Invalid load: no state change; load_err=1 for exactly the next cycle.
- Load does not affect the prescaler.
- Mid-operation reset: all state cleared on that edge. No pending carry survives.
- Elaboration checks ($error): DIV>=1, CLK_HZ divisible by TICK_HZ, each STAGE_MOD in [2, 2**STAGE_W].

Decomposition:
- Package clock_pkg: default CLK_HZ, a stage-modulus array type, the SEC_MOD/MIN_MOD/HOUR_MOD constants, and a function computing DIV_W.
- Sub-module mod_stage (params MOD, W; ports clk, rst, ce, ld, ld_val, value, at_max, carry) instantiated NUM_STAGES times via generate.
- The prescaler and load decode stay in the top module.

Test Plan:
Use CLK_HZ=10, TICK_HZ=1 (DIV=10), STAGE_MOD='{4,3,2}, STAGE_W=3 unless stated.
1. Release rst, en=1 held -> tick high on cycles 10,20,30 after release; value[0]=1,2,3 in the cycles after each tick.
2. Run 24 ticks -> carry[0] on ticks 4,8,..., carry[1] on ticks 12,24, rollover only on tick 24, all values 0 afterwards.
3. en=0 for 7 cycles at prescaler=5 -> no tick during hold; next tick exactly 5 enabled cycles after en returns. Then prescale_clr at cnt=9 -> no tick, count restarts at 0.
4. load stage1=2 -> value[1]=2 next cycle, load_err=0. Load stage0=4 and load stage=3 -> values unchanged, load_err high one cycle each.
5. step coincident with tick at value[0]=3 -> single advance: value[0]=0, value[1]+1, carry[0] one cycle.
6. rst=0 at value='{3,2,1}, prescaler=7 -> next cycle all values 0, prescaler 0, no tick/carry. After release the first tick arrives 10 cycles later.
